// File: rtl/g4_chain_ctrl.sv
// g4_chain_ctrl: walks a hash-chain in the G4 rule table.
// A search presents a packet tuple and a chain head index. The controller
// reads one table entry per hop: ISSUE drives the index, and WAIT consumes
// the registered table response. The walk ends on a match, on a null link,
// or when the hop limit is reached. Single-entry table writes go through the
// same table port (UPD state). Updates take priority over searches in IDLE.
module g4_chain_ctrl #(
  parameter int unsigned INDEX_BIT_LEN    = 11,
  parameter int unsigned PACKET_BIT_LEN   = 104,
  parameter int unsigned ENTRY_DATA_WIDTH = 60,
  parameter int unsigned MAX_HOPS         = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  // search request
  input  logic                        srch_valid,
  output logic                        srch_ready,
  input  logic [PACKET_BIT_LEN-1:0]   srch_tuple,
  input  logic [INDEX_BIT_LEN:0]      srch_start,
  // entry write request
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [INDEX_BIT_LEN:0]      upd_index,
  input  logic [ENTRY_DATA_WIDTH-1:0] upd_din,
  // lookup result
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        res_hit,
  output logic [INDEX_BIT_LEN-1:0]    res_ruleID,
  output logic [7:0]                  res_hops,
  // G4 table search port
  output logic [INDEX_BIT_LEN:0]      tbl_index,
  output logic [PACKET_BIT_LEN-1:0]   tbl_tuple,
  output logic                        tbl_we,
  output logic [ENTRY_DATA_WIDTH-1:0] tbl_din,
  input  logic                        tbl_match,
  input  logic [INDEX_BIT_LEN-1:0]    tbl_ruleID,
  input  logic [INDEX_BIT_LEN-1:0]    tbl_next_index,
  // status
  output logic                        busy
);

  // Hop counter value at which the current read is the last one allowed.
  localparam logic [7:0] LAST_HOP = 8'(MAX_HOPS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    UPD   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;

  logic [INDEX_BIT_LEN:0]      r_tbl_index;
  logic [PACKET_BIT_LEN-1:0]   r_tbl_tuple;
  logic                        r_tbl_we;
  logic [ENTRY_DATA_WIDTH-1:0] r_tbl_din;
  logic [7:0]                  r_hop;
  logic                        r_res_hit;
  logic [INDEX_BIT_LEN-1:0]    r_res_ruleID;
  logic [7:0]                  r_res_hops;

  logic                        w_srch_ready;
  logic                        w_upd_ready;
  logic                        w_srch_fire;
  logic                        w_upd_fire;
  logic                        w_advance;
  logic                        w_done_load;
  logic                        w_null_link;
  logic                        w_hop_limit;

  assign w_null_link = (tbl_next_index == '0);
  assign w_hop_limit = (r_hop == LAST_HOP);

  // Next-state and handshake decode; an update in IDLE masks the search.
  always_comb begin
    w_next_state = r_state;
    w_srch_ready = 1'b0;
    w_upd_ready  = 1'b0;
    w_srch_fire  = 1'b0;
    w_upd_fire   = 1'b0;
    w_advance    = 1'b0;
    w_done_load  = 1'b0;
    case (r_state)
      IDLE: begin
        w_upd_ready  = !rst;
        w_srch_ready = !rst && !upd_valid;
        w_upd_fire   = upd_valid && w_upd_ready;
        w_srch_fire  = srch_valid && w_srch_ready;
        if (w_upd_fire) begin
          w_next_state = UPD;
        end else if (w_srch_fire) begin
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        w_next_state = WAIT;
      end
      WAIT: begin
        if (tbl_match || w_null_link || w_hop_limit) begin
          w_done_load  = 1'b1;
          w_next_state = DONE;
        end else begin
          w_advance    = 1'b1;
          w_next_state = ISSUE;
        end
      end
      UPD: begin
        w_next_state = IDLE;
      end
      DONE: begin
        if (res_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Table port and result registers. tbl_index doubles as the walk's current
  // index, so it naturally holds its last value in IDLE and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tbl_index  <= '0;
      r_tbl_tuple  <= '0;
      r_tbl_we     <= 1'b0;
      r_tbl_din    <= '0;
      r_hop        <= '0;
      r_res_hit    <= 1'b0;
      r_res_ruleID <= '0;
      r_res_hops   <= '0;
    end else begin
      r_tbl_we <= w_upd_fire;
      if (w_upd_fire) begin
        r_tbl_index <= upd_index;
        r_tbl_din   <= upd_din;
      end
      if (w_srch_fire) begin
        r_tbl_tuple <= srch_tuple;
        r_tbl_index <= srch_start;
        r_hop       <= '0;
      end
      if (w_advance) begin
        r_tbl_index <= {1'b0, tbl_next_index};
        r_hop       <= r_hop + 8'd1;
      end
      if (w_done_load) begin
        r_res_hit    <= tbl_match;
        r_res_ruleID <= tbl_match ? tbl_ruleID : '0;
        r_res_hops   <= r_hop + 8'd1;
      end
    end
  end

  assign srch_ready = w_srch_ready;
  assign upd_ready  = w_upd_ready;
  assign res_valid  = (r_state == DONE);
  assign res_hit    = r_res_hit;
  assign res_ruleID = r_res_ruleID;
  assign res_hops   = r_res_hops;
  assign tbl_index  = r_tbl_index;
  assign tbl_tuple  = r_tbl_tuple;
  assign tbl_we     = r_tbl_we;
  assign tbl_din    = r_tbl_din;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_g4_chain_ctrl.sv
// Directed testbench for g4_chain_ctrl. A behavioural G4 table is modelled
// here. Its entry layout is {5'b0, valid, srcIP[31:0], ruleID[10:0],
// next[10:0]}. An entry matches when it is valid and its srcIP equals
// tuple[103:72]. Table outputs are registered, giving one cycle of read latency.
module tb_g4_chain_ctrl;

  localparam int IW = 11;
  localparam int PW = 104;
  localparam int EW = 60;

  localparam logic [31:0] IP_A = 32'h0A00_0001;
  localparam logic [31:0] IP_B = 32'h0A00_0002;
  localparam logic [31:0] IP_C = 32'hC0A8_0001;
  localparam logic [31:0] IP_D = 32'hDEAD_BEEF;
  localparam logic [31:0] IP_E = 32'hAC10_0005;

  logic          clk = 1'b0;
  logic          rst;
  logic          srch_valid, srch_ready;
  logic [PW-1:0] srch_tuple;
  logic [IW:0]   srch_start;
  logic          upd_valid, upd_ready;
  logic [IW:0]   upd_index;
  logic [EW-1:0] upd_din;
  logic          res_valid, res_ready, res_hit;
  logic [IW-1:0] res_ruleID;
  logic [7:0]    res_hops;
  logic [IW:0]   tbl_index;
  logic [PW-1:0] tbl_tuple;
  logic          tbl_we;
  logic [EW-1:0] tbl_din;
  logic          tbl_match = 1'b0;
  logic [IW-1:0] tbl_ruleID = '0;
  logic [IW-1:0] tbl_next_index = '0;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [IW:0] seq [0:7];
  int          seq_n;

  logic [EW-1:0] mem [0:4095] = '{default: '0};

  always #5 clk = ~clk;

  g4_chain_ctrl #(
    .INDEX_BIT_LEN(IW),
    .PACKET_BIT_LEN(PW),
    .ENTRY_DATA_WIDTH(EW),
    .MAX_HOPS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .srch_valid(srch_valid), .srch_ready(srch_ready),
    .srch_tuple(srch_tuple), .srch_start(srch_start),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_index(upd_index), .upd_din(upd_din),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_ruleID(res_ruleID), .res_hops(res_hops),
    .tbl_index(tbl_index), .tbl_tuple(tbl_tuple), .tbl_we(tbl_we),
    .tbl_din(tbl_din), .tbl_match(tbl_match), .tbl_ruleID(tbl_ruleID),
    .tbl_next_index(tbl_next_index), .busy(busy)
  );

  // Table model: write on tbl_we, registered read of the addressed entry.
  always @(posedge clk) begin
    if (tbl_we) mem[tbl_index] <= tbl_din;
    tbl_match      <= mem[tbl_index][54] && (mem[tbl_index][53:22] == tbl_tuple[103:72]);
    tbl_ruleID     <= mem[tbl_index][21:11];
    tbl_next_index <= mem[tbl_index][10:0];
  end

  function automatic logic [EW-1:0] ent(input logic v, input logic [31:0] key,
                                        input logic [10:0] rule, input logic [10:0] nxt);
    return {5'b0, v, key, rule, nxt};
  endfunction

  function automatic logic [PW-1:0] tup(input logic [31:0] ip);
    return {ip, 72'h01_2345_6789_ABCD_EF55};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic record_index();
    if (seq_n < 8 && (seq_n == 0 || seq[seq_n-1] !== tbl_index)) begin
      seq[seq_n] = tbl_index;
      seq_n++;
    end
  endtask

  task automatic write_entry(input logic [IW:0] idx, input logic [EW-1:0] d);
    int n;
    upd_valid = 1'b1;
    upd_index = idx;
    upd_din   = d;
    n = 0;
    while (!upd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!upd_ready) begin
      checks++; errors++;
      $display("FAIL upd_accept_timeout idx=%0d", idx);
      upd_valid = 1'b0;
      return;
    end
    tick();
    upd_valid = 1'b0;
    checks++;
    if (tbl_we !== 1'b1 || tbl_index !== idx || tbl_din !== d) begin
      errors++;
      $display("FAIL upd_cycle we=%b idx=%0d din=%h expected we=1 idx=%0d din=%h",
               tbl_we, tbl_index, tbl_din, idx, d);
    end
    tick();
    checks++;
    if (tbl_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL upd_end we=%b busy=%b expected 0 0", tbl_we, busy);
    end
  endtask

  // Runs one search; lat counts clock edges from the handshake edge until
  // res_valid is seen. hold keeps res_ready low for that many DONE cycles.
  task automatic do_search(input logic [IW:0] start, input logic [31:0] ip, input int hold,
                           output logic hit, output logic [IW-1:0] rule,
                           output logic [7:0] hops, output int lat);
    int n;
    hit = 1'b0; rule = '0; hops = '0; lat = -1;
    srch_valid = 1'b1;
    srch_start = start;
    srch_tuple = tup(ip);
    res_ready  = 1'b0;
    n = 0;
    while (!srch_ready && n < 50) begin
      tick();
      n++;
    end
    if (!srch_ready) begin
      checks++; errors++;
      $display("FAIL srch_accept_timeout start=%0d", start);
      srch_valid = 1'b0;
      return;
    end
    tick();
    srch_valid = 1'b0;
    lat   = 1;
    seq_n = 0;
    record_index();
    while (!res_valid && lat < 100) begin
      tick();
      lat++;
      record_index();
    end
    if (!res_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout start=%0d cycles=%0d", start, lat);
      lat = -1;
      return;
    end
    hit  = res_hit;
    rule = res_ruleID;
    hops = res_hops;
    repeat (hold) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_hit !== hit || res_ruleID !== rule ||
          res_hops !== hops || srch_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable valid=%b hit=%b rule=%h hops=%0d srdy=%b expected 1 %b %h %0d 0",
                 res_valid, res_hit, res_ruleID, res_hops, srch_ready, hit, rule, hops);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL res_release valid=%b busy=%b expected 0 0", res_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    srch_valid = 1'b0; srch_tuple = '0; srch_start = '0;
    upd_valid = 1'b0; upd_index = '0; upd_din = '0;
    res_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (srch_ready !== 1'b0 || upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready srdy=%b urdy=%b expected 0 0", srch_ready, upd_ready);
    end
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_hit !== 1'b0 ||
        res_ruleID !== '0 || res_hops !== 8'd0) begin
      errors++;
      $display("FAIL reset_res busy=%b valid=%b hit=%b rule=%h hops=%0d expected all 0",
               busy, res_valid, res_hit, res_ruleID, res_hops);
    end
    checks++;
    if (tbl_we !== 1'b0 || tbl_index !== '0 || tbl_din !== '0 || tbl_tuple !== '0) begin
      errors++;
      $display("FAIL reset_tbl we=%b idx=%h din=%h tuple=%h expected all 0",
               tbl_we, tbl_index, tbl_din, tbl_tuple);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (srch_ready !== 1'b1 || upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready srdy=%b urdy=%b expected 1 1", srch_ready, upd_ready);
    end
  endtask

  task automatic test_head_hit();
    logic hit; logic [IW-1:0] rule; logic [7:0] hops; int lat;
    write_entry(12'd5, ent(1'b1, IP_A, 11'h2A, 11'd0));
    do_search(12'd5, IP_A, 0, hit, rule, hops, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL head_latency got=%0d expected=3", lat); end
    checks++;
    if (hit !== 1'b1 || rule !== 11'h2A || hops !== 8'd1) begin
      errors++;
      $display("FAIL head_result hit=%b rule=%h hops=%0d expected 1 02a 1", hit, rule, hops);
    end
  endtask

  task automatic test_chain_hit();
    logic hit; logic [IW-1:0] rule; logic [7:0] hops; int lat;
    write_entry(12'd5,  ent(1'b1, IP_A, 11'h2A, 11'd9));
    write_entry(12'd9,  ent(1'b1, IP_B, 11'h33, 11'd12));
    write_entry(12'd12, ent(1'b1, IP_C, 11'h44, 11'd0));
    do_search(12'd5, IP_C, 0, hit, rule, hops, lat);
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL chain_latency got=%0d expected=7", lat); end
    checks++;
    if (hit !== 1'b1 || rule !== 11'h44 || hops !== 8'd3) begin
      errors++;
      $display("FAIL chain_result hit=%b rule=%h hops=%0d expected 1 044 3", hit, rule, hops);
    end
    checks++;
    if (seq_n !== 3 || seq[0] !== 12'd5 || seq[1] !== 12'd9 || seq[2] !== 12'd12) begin
      errors++;
      $display("FAIL chain_index_seq n=%0d got=%0d,%0d,%0d expected 3 5,9,12",
               seq_n, seq[0], seq[1], seq[2]);
    end
  endtask

  task automatic test_null_miss();
    logic hit; logic [IW-1:0] rule; logic [7:0] hops; int lat;
    write_entry(12'd9, ent(1'b1, IP_B, 11'h33, 11'd0));
    do_search(12'd5, IP_D, 0, hit, rule, hops, lat);
    checks++;
    if (hit !== 1'b0 || rule !== 11'h000 || hops !== 8'd2 || lat !== 5) begin
      errors++;
      $display("FAIL null_miss hit=%b rule=%h hops=%0d lat=%0d expected 0 000 2 5",
               hit, rule, hops, lat);
    end
  endtask

  task automatic test_hop_limit();
    logic hit; logic [IW-1:0] rule; logic [7:0] hops; int lat;
    write_entry(12'd1, ent(1'b1, IP_A, 11'h001, 11'd2));
    write_entry(12'd2, ent(1'b1, IP_A, 11'h002, 11'd1));
    do_search(12'd1, IP_D, 0, hit, rule, hops, lat);
    checks++;
    if (hit !== 1'b0 || rule !== 11'h000 || hops !== 8'd4 || lat !== 9) begin
      errors++;
      $display("FAIL hop_limit hit=%b rule=%h hops=%0d lat=%0d expected 0 000 4 9",
               hit, rule, hops, lat);
    end
  endtask

  task automatic test_collision_backpressure();
    logic hit; logic [IW-1:0] rule; logic [7:0] hops; int lat;
    int n;
    upd_valid  = 1'b1;
    upd_index  = 12'd12;
    upd_din    = ent(1'b1, IP_E, 11'h55, 11'd0);
    srch_valid = 1'b1;
    srch_start = 12'd12;
    srch_tuple = tup(IP_E);
    res_ready  = 1'b0;
    #1;
    checks++;
    if (srch_ready !== 1'b0 || upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL collide_ready srdy=%b urdy=%b expected 0 1", srch_ready, upd_ready);
    end
    tick();
    upd_valid = 1'b0;
    checks++;
    if (tbl_we !== 1'b1 || tbl_index !== 12'd12 || srch_ready !== 1'b0) begin
      errors++;
      $display("FAIL collide_upd we=%b idx=%0d srdy=%b expected 1 12 0", tbl_we, tbl_index, srch_ready);
    end
    tick();
    checks++;
    if (tbl_we !== 1'b0 || srch_ready !== 1'b1) begin
      errors++;
      $display("FAIL collide_idle we=%b srdy=%b expected 0 1", tbl_we, srch_ready);
    end
    tick();
    // keep a second search pending for the whole walk and DONE stall
    srch_start = 12'd5;
    srch_tuple = tup(IP_A);
    lat = 1;
    while (!res_valid && lat < 100) begin
      tick();
      lat++;
    end
    checks++;
    if (res_valid !== 1'b1 || lat !== 3 || res_hit !== 1'b1 ||
        res_ruleID !== 11'h55 || res_hops !== 8'd1) begin
      errors++;
      $display("FAIL collide_search valid=%b lat=%0d hit=%b rule=%h hops=%0d expected 1 3 1 055 1",
               res_valid, lat, res_hit, res_ruleID, res_hops);
    end
    for (n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_hit !== 1'b1 || res_ruleID !== 11'h55 ||
          res_hops !== 8'd1 || srch_ready !== 1'b0 || upd_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure cyc=%0d valid=%b hit=%b rule=%h hops=%0d srdy=%b urdy=%b expected 1 1 055 1 0 0",
                 n, res_valid, res_hit, res_ruleID, res_hops, srch_ready, upd_ready);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || srch_ready !== 1'b1) begin
      errors++;
      $display("FAIL pending_accept valid=%b srdy=%b expected 0 1", res_valid, srch_ready);
    end
    do_search(12'd5, IP_A, 0, hit, rule, hops, lat);
    checks++;
    if (hit !== 1'b1 || rule !== 11'h2A || hops !== 8'd1 || lat !== 3) begin
      errors++;
      $display("FAIL pending_result hit=%b rule=%h hops=%0d lat=%0d expected 1 02a 1 3",
               hit, rule, hops, lat);
    end
  endtask

  task automatic test_reset_midwalk();
    logic hit; logic [IW-1:0] rule; logic [7:0] hops; int lat;
    int n;
    srch_valid = 1'b1;
    srch_start = 12'd5;
    srch_tuple = tup(IP_D);
    res_ready  = 1'b0;
    n = 0;
    while (!srch_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    srch_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || tbl_index !== 12'd9) begin
      errors++;
      $display("FAIL midwalk_pos busy=%b idx=%0d expected 1 9", busy, tbl_index);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || tbl_we !== 1'b0 || tbl_index !== '0 ||
        srch_ready !== 1'b0 || upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL midwalk_reset busy=%b valid=%b we=%b idx=%0d srdy=%b urdy=%b expected 0 0 0 0 0 0",
               busy, res_valid, tbl_we, tbl_index, srch_ready, upd_ready);
    end
    rst = 1'b0;
    n = 0;
    repeat (4) begin
      tick();
      if (res_valid !== 1'b0 || busy !== 1'b0) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL midwalk_no_result bad_cycles=%0d expected 0", n);
    end
    do_search(12'd12, IP_E, 0, hit, rule, hops, lat);
    checks++;
    if (hit !== 1'b1 || rule !== 11'h55 || hops !== 8'd1 || lat !== 3) begin
      errors++;
      $display("FAIL after_reset hit=%b rule=%h hops=%0d lat=%0d expected 1 055 1 3",
               hit, rule, hops, lat);
    end
  endtask

  initial begin
    test_reset();
    test_head_hit();
    test_chain_hit();
    test_null_miss();
    test_hop_limit();
    test_collision_backpressure();
    test_reset_midwalk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/g4_chain_ctrl.md
G4_CHAIN_CTRL -- requirements
Module: g4_chain_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BIT_LEN, default 11, table index/ruleID width.
REQ-002 SHALL have parameter PACKET_BIT_LEN, default 104, packet tuple width.
REQ-003 SHALL have parameter ENTRY_DATA_WIDTH, default 60, table entry width.
REQ-004 SHALL have parameter MAX_HOPS, default 8, chain-walk limit (range 1..255).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports srch_valid input 1, srch_ready output 1; the search request handshake.
REQ-008 SHALL have ports srch_tuple input PACKET_BIT_LEN, srch_start input INDEX_BIT_LEN+1; packet and chain head index.
REQ-009 SHALL have ports upd_valid input 1, upd_ready output 1, upd_index input INDEX_BIT_LEN+1, upd_din input ENTRY_DATA_WIDTH; the entry write request.
REQ-010 SHALL have ports res_valid output 1, res_ready input 1, res_hit output 1, res_ruleID output INDEX_BIT_LEN, res_hops output 8; the lookup result.
REQ-011 SHALL have ports tbl_index output INDEX_BIT_LEN+1, tbl_tuple output PACKET_BIT_LEN, tbl_we output 1, tbl_din output ENTRY_DATA_WIDTH; drive the G4 table search port.
REQ-012 SHALL have ports tbl_match input 1, tbl_ruleID input INDEX_BIT_LEN, tbl_next_index input INDEX_BIT_LEN; registered table outputs, one-cycle read latency.
REQ-013 SHALL have port busy  output 1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT, UPD, DONE.
REQ-015 In IDLE, upd_ready SHALL be 1; srch_ready SHALL be !upd_valid, so an update wins over a simultaneous search.
REQ-016 An update handshake in IDLE SHALL latch upd_index/upd_din and go to UPD.
REQ-017 UPD SHALL last exactly one cycle with tbl_we=1, tbl_index=latched upd_index, tbl_din=latched upd_din; it then returns to IDLE.
REQ-018 A search handshake SHALL latch srch_tuple into tbl_tuple, set cur_index=srch_start and hop=0, and go to ISSUE.
REQ-019 ISSUE SHALL drive tbl_index=cur_index with tbl_we=0 for one cycle, then go to WAIT.
REQ-020 WAIT SHALL sample tbl_match/tbl_ruleID/tbl_next_index, taking the first applicable case:
- match: res_hit=1, res_ruleID=tbl_ruleID, go to DONE.
- tbl_next_index==0 (null link): res_hit=0, res_ruleID=0, go to DONE.
- hop==MAX_HOPS-1: res_hit=0, res_ruleID=0, go to DONE.
- otherwise: cur_index={1'b0,tbl_next_index}, hop+1, go to ISSUE.
REQ-021 res_hops SHALL equal the number of entries read, hop+1, captured on the WAIT->DONE transition.
REQ-022 Each hop SHALL cost 2 cycles; a hit at the head SHALL assert res_valid 3 cycles after the search handshake edge.
REQ-023 DONE SHALL hold res_valid=1 and hold all res_* stable until res_ready=1; the handshake cycle returns to IDLE with res_valid=0 next cycle.
REQ-024 srch_ready and upd_ready SHALL be 0 outside IDLE; requests arriving then SHALL wait and SHALL NOT be dropped.
REQ-025 tbl_we SHALL be 1 only in UPD; tbl_index SHALL hold its last value in IDLE and DONE.
REQ-026 An entry written in UPD SHALL be visible to any search accepted afterwards; no bypass is required.

Reset
REQ-027 When rst=1 at a clock edge: state=IDLE; res_valid=0, res_hit=0, res_ruleID=0, res_hops=0, tbl_we=0, tbl_index=0, tbl_din=0, tbl_tuple=0, busy=0.
REQ-028 Reset in any state, including mid-walk or in UPD, SHALL abort the operation, produce no result, and leave tbl_we=0 from the next cycle.
REQ-029 srch_ready and upd_ready SHALL be 0 while rst=1.

Verification
REQ-030 Head hit: table[5] srcIP match with ruleID 0x2A; search start=5 -> res_valid 3 cycles later, res_hit=1, res_ruleID=0x2A, res_hops=1.
REQ-031 Chain hit: 5->9->12, match at 12 -> res_hit=1, res_hops=3, res_valid 7 cycles after the handshake, tbl_index sequence 5,9,12.
REQ-032 Null miss: 5->9, next 0 at 9, no match -> res_hit=0, res_ruleID=0, res_hops=2.
REQ-033 Hop limit: MAX_HOPS=4, cyclic chain 1->2->1... -> res_hit=0, res_hops=4, no hang.
REQ-034 Collision/backpressure: upd_valid and srch_valid together in IDLE -> UPD first (tbl_we=1 one cycle) and the search is accepted the next IDLE cycle; res_ready=0 for 5 cycles -> res_* stable and srch_ready=0 throughout.
REQ-035 Reset mid-walk: rst pulsed during WAIT of hop 2 -> busy=0, res_valid=0, tbl_we=0 next cycle, and a fresh search then completes correctly.
